// File: rtl/axi_rd_arbiter.sv
// Two-master AXI3 read-channel arbiter: round-robin AR grant with a per-master
// outstanding-burst limit, and R beats steered to the owning master by rid.
module axi_rd_arbiter #(
    parameter logic [3:0] M0_ID   = 4'd0,
    parameter logic [3:0] M1_ID   = 4'd1,
    parameter int         MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic [3:0]  m0_arid,
    input  logic [31:0] m0_araddr,
    input  logic [3:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    input  logic        m0_arvalid,
    output logic        m0_arready,

    input  logic [3:0]  m1_arid,
    input  logic [31:0] m1_araddr,
    input  logic [3:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    input  logic        m1_arvalid,
    output logic        m1_arready,

    output logic [3:0]  s_arid,
    output logic [31:0] s_araddr,
    output logic [3:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    output logic        s_arvalid,
    input  logic        s_arready,

    input  logic [3:0]  s_rid,
    input  logic        s_rlast,
    input  logic        s_rvalid,
    output logic        s_rready,

    output logic        m0_rvalid,
    output logic        m1_rvalid,
    input  logic        m0_rready,
    input  logic        m1_rready,

    output logic        err_rid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);

    state_t     state_reg, state_next;
    logic       last_grant_reg, last_grant_next;
    logic       err_rid_reg;

    logic [1:0] m_arvalid;
    logic [1:0] elig;
    logic [1:0] ar_inc;
    logic [1:0] rid_hit;
    logic [1:0] rd_done;
    logic       rid_known;

    assign m_arvalid = {m1_arvalid, m0_arvalid};

    // R steering; M0_ID takes priority should both ids ever be configured equal
    assign rid_hit[0] = (s_rid == M0_ID);
    assign rid_hit[1] = (s_rid == M1_ID) && !rid_hit[0];
    assign rid_known  = |rid_hit;

    assign m0_rvalid = s_rvalid && rid_hit[0];
    assign m1_rvalid = s_rvalid && rid_hit[1];
    assign s_rready  = rid_hit[0] ? m0_rready :
                       rid_hit[1] ? m1_rready : 1'b1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [1:0] cnt_reg;

            assign rd_done[gi] = s_rvalid && s_rready && s_rlast && rid_hit[gi];
            assign elig[gi]    = m_arvalid[gi] && (cnt_reg < MAX_CNT);

            // Simultaneous inc/dec cancel; dec saturates at 0 so stale beats after reset are harmless
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    cnt_reg <= 2'd0;
                end else if (ar_inc[gi] && !rd_done[gi]) begin
                    if (cnt_reg < MAX_CNT) begin
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                end else if (rd_done[gi] && !ar_inc[gi] && (cnt_reg != 2'd0)) begin
                    cnt_reg <= cnt_reg - 2'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            err_rid_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            if (s_rvalid && !rid_known) begin
                err_rid_reg <= 1'b1;
            end
        end
    end

    assign err_rid = err_rid_reg;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        ar_inc          = 2'b00;
        s_arvalid       = 1'b0;
        m0_arready      = 1'b0;
        m1_arready      = 1'b0;
        s_arid          = 4'd0;
        s_araddr        = 32'd0;
        s_arlen         = 4'd0;
        s_arsize        = 3'd0;
        s_arburst       = 2'd0;

        case (state_reg)
            IDLE: begin
                if (elig[0] && elig[1]) begin
                    state_next = last_grant_reg ? GNT0 : GNT1;
                end else if (elig[0]) begin
                    state_next = GNT0;
                end else if (elig[1]) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                s_arvalid  = 1'b1;
                s_arid     = m0_arid;
                s_araddr   = m0_araddr;
                s_arlen    = m0_arlen;
                s_arsize   = m0_arsize;
                s_arburst  = m0_arburst;
                m0_arready = s_arready;
                if (s_arready) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b0;
                    ar_inc[0]       = 1'b1;
                end
            end
            GNT1: begin
                s_arvalid  = 1'b1;
                s_arid     = m1_arid;
                s_araddr   = m1_araddr;
                s_arlen    = m1_arlen;
                s_arsize   = m1_arsize;
                s_arburst  = m1_arburst;
                m1_arready = s_arready;
                if (s_arready) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b1;
                    ar_inc[1]       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter against a transaction-level model of
// grant ownership, outstanding-burst counts and rid routing.
module tb_axi_rd_arbiter;

    localparam logic [3:0] ID0     = 4'd0;
    localparam logic [3:0] ID1     = 4'd1;
    localparam int         MAX_OUT = 2;
    localparam int         N_CYC   = 4000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [44:0] m_pay [2];
    logic        m_arv [2];
    logic [3:0]  m0_arid, m1_arid, s_arid;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic [3:0]  m0_arlen, m1_arlen, s_arlen;
    logic [2:0]  m0_arsize, m1_arsize, s_arsize;
    logic [1:0]  m0_arburst, m1_arburst, s_arburst;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic        s_arvalid, s_arready;
    logic [3:0]  s_rid;
    logic        s_rlast, s_rvalid, s_rready;
    logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic        err_rid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign {m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst} = m_pay[0];
    assign {m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst} = m_pay[1];
    assign m0_arvalid = m_arv[0];
    assign m1_arvalid = m_arv[1];

    axi_rd_arbiter #(.M0_ID(ID0), .M1_ID(ID1), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rstn(rstn),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rready(m0_rready), .m1_rready(m1_rready),
        .err_rid(err_rid)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [44:0] rand_pay(input logic [3:0] id);
        logic [31:0] a;
        a = $urandom;
        return {id, a, 4'($urandom), 3'($urandom), 2'($urandom)};
    endfunction

    // Reference model: who currently owns the AR slot (-1 = nobody), who won last,
    // how many bursts each master has in flight, and the sticky rid error.
    int owner, last, outs [2];
    bit err_m;

    initial begin
        bit          hs [2];
        bit          e0, e1, known, exp_rr;
        int          idx, inc, dec, rst_left;
        logic [44:0] exp_pay;

        rstn = 1'b0;
        m_arv[0] = 1'b0; m_arv[1] = 1'b0;
        m_pay[0] = '0;   m_pay[1] = '0;
        s_arready = 1'b0; s_rid = 4'd0; s_rlast = 1'b0; s_rvalid = 1'b0;
        m0_rready = 1'b0; m1_rready = 1'b0;
        hs[0] = 1'b0; hs[1] = 1'b0;
        rst_left = 0;
        repeat (2) @(posedge clk);
        owner = -1; last = 1; outs[0] = 0; outs[1] = 0; err_m = 1'b0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            if (rst_left == 0 && $urandom_range(299) == 0) rst_left = $urandom_range(3, 1);
            if (rst_left > 0) begin
                rstn = 1'b0;
                rst_left--;
            end else begin
                rstn = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (!rstn) begin
                    m_arv[i] = 1'b0;
                end else if (!(m_arv[i] && !hs[i])) begin
                    m_arv[i] = ($urandom_range(1) == 0);
                    m_pay[i] = rand_pay(i == 0 ? ID0 : ID1);
                end
            end
            s_arready = ($urandom_range(9) < 6);
            s_rvalid  = ($urandom_range(9) < 3);
            s_rlast   = ($urandom_range(9) < 4);
            idx = $urandom_range(39);
            s_rid = (idx < 19) ? ID0 : (idx < 38) ? ID1 : 4'($urandom);
            m0_rready = ($urandom_range(1) == 0);
            m1_rready = ($urandom_range(1) == 0);

            @(negedge clk);
            exp_pay = (owner >= 0) ? m_pay[owner] : 45'd0;
            known   = (s_rid == ID0) || (s_rid == ID1);
            idx     = (s_rid == ID0) ? 0 : (s_rid == ID1) ? 1 : -1;
            exp_rr  = (idx == 0) ? m0_rready : (idx == 1) ? m1_rready : 1'b1;

            check_eq("s_arvalid",  64'(s_arvalid),  64'(owner >= 0));
            check_eq("s_ar_pay",   64'({s_arid, s_araddr, s_arlen, s_arsize, s_arburst}), 64'(exp_pay));
            check_eq("m0_arready", 64'(m0_arready), 64'(owner == 0 && s_arready));
            check_eq("m1_arready", 64'(m1_arready), 64'(owner == 1 && s_arready));
            check_eq("m0_rvalid",  64'(m0_rvalid),  64'(s_rvalid && idx == 0));
            check_eq("m1_rvalid",  64'(m1_rvalid),  64'(s_rvalid && idx == 1));
            check_eq("s_rready",   64'(s_rready),   64'(exp_rr));
            check_eq("err_rid",    64'(err_rid),    64'(err_m));

            for (int i = 0; i < 2; i++) hs[i] = m_arv[i] && owner == i && s_arready;

            if (!rstn) begin
                owner = -1; last = 1; outs[0] = 0; outs[1] = 0; err_m = 1'b0;
            end else begin
                inc = -1;
                if (owner < 0) begin
                    e0 = m_arv[0] && outs[0] < MAX_OUT;
                    e1 = m_arv[1] && outs[1] < MAX_OUT;
                    if (e0 && e1)  owner = 1 - last;
                    else if (e0)   owner = 0;
                    else if (e1)   owner = 1;
                end else if (s_arready) begin
                    $display("AR grant m%0d addr=%h len=%0d outstanding=%0d",
                             owner, m_pay[owner][40:9], m_pay[owner][8:5], outs[owner] + 1);
                    inc   = owner;
                    last  = owner;
                    owner = -1;
                end
                dec = (s_rvalid && exp_rr && s_rlast && known) ? idx : -1;
                for (int i = 0; i < 2; i++) begin
                    if (inc == i && dec == i) ;
                    else if (inc == i)              outs[i]++;
                    else if (dec == i && outs[i] > 0) outs[i]--;
                end
                if (s_rvalid && !known) err_m = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
